// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_pkg
// Description : Shared glyph type, blank glyph constant and the count-width
//               helper for the seven-segment character buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

    localparam int GLYPH_W = 8;

    typedef logic [GLYPH_W-1:0] glyph_t;

    // All segments off
    localparam glyph_t BLANK_GLYPH = '0;

    // Width that holds 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : seg_disp_pkg
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ============================================================================
// Module      : btn_repeat
// Description : Converts a held button level into delete pulses: one on the
//               rising edge, then optional auto-repeat after a hold delay.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat #(
    parameter int REPEAT_DELAY  = 0,
    parameter int REPEAT_PERIOD = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int c_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_HW  = $clog2(c_MAX + 2);

    logic r_btn_q;
    logic w_rise;
    logic w_auto;

    assign w_rise = btn & ~r_btn_q;
    assign pulse  = w_rise | w_auto;

    // Previous button level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_btn_q <= 1'b0;
        else     r_btn_q <= btn;
    end

    generate
        if (REPEAT_DELAY > 0) begin : g_repeat
            // r_hold equals the hold-cycle index until the first repeat, then
            // counts 1..REPEAT_PERIOD between repeats (r_rep set).
            logic [c_HW-1:0] r_hold;
            logic            r_rep;

            assign w_auto = btn & r_btn_q &
                            ((~r_rep & (r_hold == c_HW'(REPEAT_DELAY))) |
                             ( r_rep & (r_hold == c_HW'(REPEAT_PERIOD))));

            // Hold counter, cleared whenever the button is released
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_hold <= '0;
                    r_rep  <= 1'b0;
                end else if (!btn) begin
                    r_hold <= '0;
                    r_rep  <= 1'b0;
                end else if (w_auto) begin
                    r_hold <= c_HW'(1);
                    r_rep  <= 1'b1;
                end else begin
                    r_hold <= r_hold + c_HW'(1);
                end
            end
        end else begin : g_no_repeat
            assign w_auto = 1'b0;
        end
    endgenerate

endmodule : btn_repeat
`default_nettype wire

// File: rtl/seg_char_buffer.sv
`default_nettype none
// ============================================================================
// Module      : seg_char_buffer
// Description : Glyph buffer for the seven-segment display. Newest glyph in
//               slot 0; supports append, backspace with repeat, and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_char_buffer
    import seg_disp_pkg::*;
#(
    parameter int                CHAR_W        = 8,
    parameter int                DEPTH         = 8,
    parameter logic [CHAR_W-1:0] BLANK         = CHAR_W'(BLANK_GLYPH),
    parameter int                SCROLL        = 1,
    parameter int                REPEAT_DELAY  = 0,
    parameter int                REPEAT_PERIOD = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_valid,
    input  logic [CHAR_W-1:0]           push_char,
    output logic                        push_ready,
    input  logic                        bksp_btn,
    input  logic                        clr,
    output logic [DEPTH*CHAR_W-1:0]     buf_out,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        full,
    output logic                        empty,
    output logic                        err
);

    localparam int               CNT_W       = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic             c_SCROLL    = (SCROLL != 0);

    localparam logic [1:0] c_OP_NONE = 2'd0;
    localparam logic [1:0] c_OP_CLR  = 2'd1;
    localparam logic [1:0] c_OP_DEL  = 2'd2;
    localparam logic [1:0] c_OP_PUSH = 2'd3;

    logic [CHAR_W-1:0] r_slot [DEPTH];
    logic              w_del;
    logic              w_full_ok;
    logic [1:0]        w_op;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_err_nxt;

    btn_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_btn_repeat (
        .clk   (clk),
        .rst   (rst),
        .btn   (bksp_btn),
        .pulse (w_del)
    );

    assign w_full_ok  = ~full | c_SCROLL;
    assign push_ready = ~clr & ~w_del & w_full_ok;

    // Select the single operation for this cycle: clr > del > push
    always_comb begin
        w_op      = c_OP_NONE;
        w_cnt_nxt = count;
        w_err_nxt = 1'b0;
        if (clr) begin
            w_op      = c_OP_CLR;
            w_cnt_nxt = '0;
        end else if (w_del) begin
            if (!empty) begin
                w_op      = c_OP_DEL;
                w_cnt_nxt = count - CNT_W'(1);
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (push_valid) begin
            if (w_full_ok) begin
                w_op      = c_OP_PUSH;
                w_cnt_nxt = full ? count : count + CNT_W'(1);
            end else begin
                w_err_nxt = 1'b1;
            end
        end
    end

    // Glyph shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) r_slot[k] <= BLANK;
        end else begin
            case (w_op)
                c_OP_CLR: begin
                    for (int k = 0; k < DEPTH; k++) r_slot[k] <= BLANK;
                end
                c_OP_DEL: begin
                    for (int k = 0; k < DEPTH - 1; k++) r_slot[k] <= r_slot[k+1];
                    r_slot[DEPTH-1] <= BLANK;
                end
                c_OP_PUSH: begin
                    for (int k = DEPTH - 1; k > 0; k--) r_slot[k] <= r_slot[k-1];
                    r_slot[0] <= push_char;
                end
                default: ;
            endcase
        end
    end

    // Count and status flags, registered from the next count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            err   <= 1'b0;
        end else begin
            count <= w_cnt_nxt;
            full  <= (w_cnt_nxt == c_DEPTH_CNT);
            empty <= (w_cnt_nxt == '0);
            err   <= w_err_nxt;
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_out
            assign buf_out[k*CHAR_W +: CHAR_W] = r_slot[k];
        end
    endgenerate

endmodule : seg_char_buffer
`default_nettype wire

// File: tb/tb_seg_char_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_char_buffer
// Description : Directed self-checking bench. Three buffers share stimulus:
//               u_a (DEPTH 8, repeat 10/4), u_b (DEPTH 4, scroll),
//               u_c (DEPTH 4, no scroll).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_char_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [7:0]  push_char;
    logic        bksp_btn;
    logic        clr;

    logic        a_ready, a_full, a_empty, a_err;
    logic [63:0] a_buf;
    logic [3:0]  a_cnt;
    logic        b_ready, b_full, b_empty, b_err;
    logic [31:0] b_buf;
    logic [2:0]  b_cnt;
    logic        c_ready, c_full, c_empty, c_err;
    logic [31:0] c_buf;
    logic [2:0]  c_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    seg_char_buffer #(.DEPTH(8), .SCROLL(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) u_a (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_char(push_char),
        .push_ready(a_ready), .bksp_btn(bksp_btn), .clr(clr), .buf_out(a_buf),
        .count(a_cnt), .full(a_full), .empty(a_empty), .err(a_err));

    seg_char_buffer #(.DEPTH(4), .SCROLL(1)) u_b (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_char(push_char),
        .push_ready(b_ready), .bksp_btn(bksp_btn), .clr(clr), .buf_out(b_buf),
        .count(b_cnt), .full(b_full), .empty(b_empty), .err(b_err));

    seg_char_buffer #(.DEPTH(4), .SCROLL(0)) u_c (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_char(push_char),
        .push_ready(c_ready), .bksp_btn(bksp_btn), .clr(clr), .buf_out(c_buf),
        .count(c_cnt), .full(c_full), .empty(c_empty), .err(c_err));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] ch);
        push_valid = 1'b1;
        push_char  = ch;
        tick();
        push_valid = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        rst = 1'b1; push_valid = 1'b0; push_char = 8'h00; bksp_btn = 1'b0; clr = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_cnt",   a_cnt,   0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full",  a_full,  0);
        chk("rst_err",   a_err,   0);
        chk("rst_buf",   a_buf,   64'h0);
        rst = 1'b0;
        tick();

        // Three pushes
        push(8'h77); push(8'h7C); push(8'h39);
        chk("abc_buf",   a_buf,   64'h0000_0000_0077_7C39);
        chk("abc_cnt",   a_cnt,   3);
        chk("abc_empty", a_empty, 0);
        chk("abc_cnt_c", c_cnt,   3);

        // Single backspace
        bksp_btn = 1'b1; tick(); bksp_btn = 1'b0;
        chk("del_buf", a_buf, 64'h0000_0000_0000_777C);
        chk("del_cnt", a_cnt, 2);
        chk("del_err", a_err, 0);
        tick();

        // Clear with push offered: push refused, buffer emptied
        clr = 1'b1; push_valid = 1'b1; push_char = 8'h55;
        #1;
        chk("clr_ready", a_ready, 0);
        tick();
        clr = 1'b0; push_valid = 1'b0;
        chk("clr_cnt",   a_cnt,   0);
        chk("clr_empty", a_empty, 1);
        chk("clr_err",   a_err,   0);
        chk("clr_buf",   a_buf,   64'h0);

        // Delete on empty
        bksp_btn = 1'b1; tick(); bksp_btn = 1'b0;
        chk("dempty_err", a_err, 1);
        chk("dempty_cnt", a_cnt, 0);
        tick();
        chk("dempty_err_clr", a_err, 0);

        // Fill DEPTH 4 buffers, then a fifth push
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        chk("fill_b_full", b_full, 1);
        chk("fill_c_full", c_full, 1);
        chk("fill_c_err",  c_err,  0);
        push_valid = 1'b1; push_char = 8'h05;
        #1;
        chk("full_b_ready", b_ready, 1);
        chk("full_c_ready", c_ready, 0);
        tick();
        push_valid = 1'b0;
        chk("scroll_b_buf", b_buf, 32'h0203_0405);
        chk("scroll_b_cnt", b_cnt, 4);
        chk("scroll_b_err", b_err, 0);
        chk("refuse_c_buf", c_buf, 32'h0102_0304);
        chk("refuse_c_cnt", c_cnt, 4);
        chk("refuse_c_err", c_err, 1);
        chk("five_a_buf",   a_buf, 64'h0000_0001_0203_0405);
        tick();
        chk("refuse_c_err_clr", c_err, 0);

        // Push colliding with a delete pulse
        push_valid = 1'b1; push_char = 8'hAA; bksp_btn = 1'b1;
        #1;
        chk("coll_ready", a_ready, 0);
        tick();
        chk("coll_del_buf", a_buf, 64'h0000_0000_0102_0304);
        chk("coll_ready2",  a_ready, 1);
        tick();
        push_valid = 1'b0; bksp_btn = 1'b0;
        chk("coll_push_buf", a_buf, 64'h0000_0001_0203_04AA);
        chk("coll_push_cnt", a_cnt, 5);
        tick();

        // Hold backspace 20 cycles: deletes at hold cycles 0, 10, 14, 18
        exp_cnt = 5;
        bksp_btn = 1'b1;
        for (int h = 0; h < 20; h++) begin
            tick();
            if (h == 0 || h == 10 || h == 14 || h == 18) exp_cnt--;
            chk($sformatf("rep_cnt_h%0d", h), a_cnt, exp_cnt);
        end
        bksp_btn = 1'b0;
        tick();
        chk("rep_buf", a_buf, 64'h01);

        // Reset in the middle of a held backspace
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("pre_rst_cnt", a_cnt, 5);
        bksp_btn = 1'b1;
        tick();
        chk("pre_rst_del", a_buf, 64'h0000_0000_0111_2233);
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cnt",   a_cnt,   0);
        chk("async_rst_buf",   a_buf,   64'h0);
        chk("async_rst_empty", a_empty, 1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_err", a_err, 1);
        chk("post_rst_cnt", a_cnt, 0);
        tick();
        chk("post_rst_once", a_err, 0);
        tick(); tick();
        chk("post_rst_quiet", a_err, 0);
        bksp_btn = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_seg_char_buffer
`default_nettype wire
